demux_scan_1to8: RTL

DEMUX_SCAN_1TO8 -- requirements
Module: demux_scan_1to8

---
 rtl/demux_scan_1to8.sv | 110 +++++++++++
 1 files changed

// File: rtl/demux_scan_1to8.sv
// demux_scan_1to8: distributes a serial data bit to one of eight registered
// channels, either by explicit select or by an auto-scan pointer that
// assembles complete 8-bit frames.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   din         data bit to distribute
//   din_valid   din is accepted on this edge
//   sel_mode    0: explicit select, 1: auto-scan
//   sel         destination channel in explicit mode
//   clr         synchronous clear of channels and scan state (wins over din_valid)
//   y           registered channel outputs, channel k on y[k]
//   frame       last complete auto-scan frame
//   frame_valid one-cycle pulse when frame updates
//   ptr         next auto-scan channel
//   busy        partial auto-scan frame in progress
module demux_scan_1to8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic       din_valid,
    input  logic       sel_mode,
    input  logic [2:0] sel,
    input  logic       clr,
    output logic [7:0] y,
    output logic [7:0] frame,
    output logic       frame_valid,
    output logic [2:0] ptr,
    output logic       busy
);

    localparam int unsigned NCH   = 8;
    localparam int unsigned PTR_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NCH-1:0]     y_q, y_d;
    logic [NCH-1:0]     frame_q, frame_d;
    logic               fv_q, fv_d;
    logic               busy_q;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            y_q     <= '0;
            frame_q <= '0;
            fv_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            y_q     <= y_d;
            frame_q <= frame_d;
            fv_q    <= fv_d;
            busy_q  <= (state_d == FILL);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        y_d     = y_q;
        frame_d = frame_q;
        fv_d    = 1'b0;

        if (clr) begin
            state_d = IDLE;
            ptr_d   = '0;
            y_d     = '0;
            frame_d = '0;
        end else if (!sel_mode) begin
            // Leaving auto-scan mid-frame drops the partial frame; y is kept
            if (state_q == FILL) begin
                state_d = IDLE;
                ptr_d   = '0;
            end
            if (din_valid) begin
                y_d[sel] = din;
            end
        end else if (din_valid) begin
            y_d[ptr_q] = din;
            if (ptr_q == PTR_W'(NCH - 1)) begin
                // Frame captures y including the bit written on this edge
                state_d = IDLE;
                ptr_d   = '0;
                frame_d = y_d;
                fv_d    = 1'b1;
            end else begin
                state_d = FILL;
                ptr_d   = ptr_q + PTR_W'(1);
            end
        end
    end

    assign y           = y_q;
    assign frame       = frame_q;
    assign frame_valid = fv_q;
    assign ptr         = ptr_q;
    assign busy        = busy_q;

endmodule
